// File: rtl/key_event_pkg.sv
// key_event_pkg: shared FSM state type and sizing helpers for the key event generator
package key_event_pkg;

  typedef enum logic [2:0] {S_UP, S_DB_DN, S_HOLD, S_RPT, S_DB_UP} key_fsm_e;

  function automatic int ms_div(input int f_clk);
    return f_clk / 1000;
  endfunction

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// key_event_fsm: per-key synchroniser, debounce/auto-repeat FSM and registered event outputs
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int REPEAT_EN       = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  input  logic i_tick,
  output logic o_key_state,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int W = cnt_w(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam logic [W-1:0] DB_END = W'(DEBOUNCE_MS - 1);
  localparam logic [W-1:0] RD_END = W'(REPEAT_DELAY_MS - 1);
  localparam logic [W-1:0] RR_END = W'(REPEAT_RATE_MS - 1);

  logic [1:0]   r_sync;
  key_fsm_e     r_state;
  logic [W-1:0] r_cnt;
  logic         r_key_state;
  logic         r_press;
  logic         r_release;
  logic         r_repeat;
  logic         w_k;

  assign w_k         = r_sync[1];
  assign o_key_state = r_key_state;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_repeat    = r_repeat;

  // two-flop synchroniser for the asynchronous raw key, idles released
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_key};

  // debounce / hold / repeat FSM; a key change beats a coincident ms tick
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= S_UP;
      r_cnt       <= '0;
      r_key_state <= 1'b1;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        S_UP:
          if (!w_k) begin
            r_state <= S_DB_DN;
            r_cnt   <= '0;
          end
        S_DB_DN:
          if (w_k) r_state <= S_UP;
          else if (i_tick) begin
            if (r_cnt == DB_END) begin
              r_state     <= S_HOLD;
              r_cnt       <= '0;
              r_press     <= 1'b1;
              r_key_state <= 1'b0;
            end else r_cnt <= r_cnt + 1'b1;
          end
        S_HOLD:
          if (w_k) begin
            r_state <= S_DB_UP;
            r_cnt   <= '0;
          end else if (i_tick) begin
            if (REPEAT_EN != 0 && r_cnt == RD_END) begin
              r_state  <= S_RPT;
              r_cnt    <= '0;
              r_repeat <= 1'b1;
            end else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end
        S_RPT:
          if (w_k) begin
            r_state <= S_DB_UP;
            r_cnt   <= '0;
          end else if (i_tick) begin
            if (r_cnt == RR_END) begin
              r_cnt    <= '0;
              r_repeat <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
        S_DB_UP:
          if (!w_k) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else if (i_tick) begin
            if (r_cnt == DB_END) begin
              r_state     <= S_UP;
              r_cnt       <= '0;
              r_release   <= 1'b1;
              r_key_state <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
        default: r_state <= S_UP;
      endcase
    end

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: shared 1 ms tick plus one debounce/repeat FSM per active-low key
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int F_CLK           = 50000000,
  parameter int N_KEYS          = 6,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int REPEAT_EN       = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_key_state,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_repeat
);

  localparam int DIV = ms_div(F_CLK);
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic          w_tick;

  assign w_tick = r_div == DIV_END;

  // millisecond prescaler; tick is the single cycle at the terminal count
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_div <= '0;
    else          r_div <= w_tick ? '0 : r_div + 1'b1;

  genvar k;
  for (k = 0; k < N_KEYS; k++) begin : g_key
    key_event_fsm #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS),
      .REPEAT_EN      (REPEAT_EN)
    ) u_fsm (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_key      (i_key[k]),
      .i_tick     (w_tick),
      .o_key_state(o_key_state[k]),
      .o_press    (o_press[k]),
      .o_release  (o_release[k]),
      .o_repeat   (o_repeat[k])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: randomized directed key waveforms checked against an ms-level event model
module tb_key_event_gen;

  localparam int F = 10000, NK = 2, DB = 3, RD = 10, RR = 4, MS = 10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key   = '1;
  logic [NK-1:0] st[2], pr[2], rl[2], rp[2];

  key_event_gen #(.F_CLK(F), .N_KEYS(NK), .DEBOUNCE_MS(DB), .REPEAT_DELAY_MS(RD),
                  .REPEAT_RATE_MS(RR), .REPEAT_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_key_state(st[0]), .o_press(pr[0]), .o_release(rl[0]), .o_repeat(rp[0]));

  key_event_gen #(.F_CLK(F), .N_KEYS(NK), .DEBOUNCE_MS(DB), .REPEAT_DELAY_MS(RD),
                  .REPEAT_RATE_MS(RR), .REPEAT_EN(0)) dut_nr (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_key_state(st[1]), .o_press(pr[1]), .o_release(rl[1]), .o_repeat(rp[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int d; int k; int kind; int t;} act_t;
  typedef struct {int k; int kind; int lo; int hi;} exp_t;

  act_t  act_q[$];
  exp_t  exp_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    seg_start[NK], next_rep[NK];
  logic  lvl[NK];
  bit    pressed[NK], seen[NK];
  string kn[3] = '{"press", "release", "repeat"};

  // record every output pulse of both builds with the posedge count it came from
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NK; k++) begin
        if (pr[d][k]) act_q.push_back('{d, k, 0, cyc});
        if (rl[d][k]) act_q.push_back('{d, k, 1, cyc});
        if (rp[d][k]) act_q.push_back('{d, k, 2, cyc});
      end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int t, input int lo, input int hi);
    n_cmp++;
    assert (t >= lo && t <= hi) else begin
      n_bad++;
      $error("FAIL %s: got cycle %0d, want %0d..%0d", tag, t, lo, hi);
    end
  endtask

  function automatic void expect_ev(int k, int kind, int nom);
    exp_q.push_back('{k, kind, nom - MS, nom + MS + 3});
  endfunction

  // model: a key segment of constant raw level from seg_start to t1 yields events
  function automatic void fin(int k, int t1);
    int d;
    d = t1 - seg_start[k];
    if (!lvl[k]) begin
      if (!pressed[k] && d > DB * MS) begin
        expect_ev(k, 0, seg_start[k] + DB * MS);
        pressed[k]  = 1'b1;
        next_rep[k] = seg_start[k] + (DB + RD) * MS;
      end else if (pressed[k] && !seen[k]) next_rep[k] = seg_start[k] + RD * MS;
      if (pressed[k])
        while (next_rep[k] < t1) begin
          expect_ev(k, 2, next_rep[k]);
          next_rep[k] += RR * MS;
        end
    end else if (pressed[k] && d > DB * MS) begin
      expect_ev(k, 1, seg_start[k] + DB * MS);
      pressed[k] = 1'b0;
    end
    seen[k] = 1'b1;
  endfunction

  task automatic seg(input logic [NK-1:0] lv, input int n);
    for (int k = 0; k < NK; k++)
      if (lv[k] !== lvl[k]) begin
        fin(k, cyc);
        seg_start[k] = cyc;
        lvl[k]       = lv[k];
        seen[k]      = 1'b0;
      end
    key = lv;
    repeat (n) @(negedge clk);
  endtask

  task automatic flush(input string tag);
    exp_t          e[$];
    act_t          a[$];
    logic [NK-1:0] want;
    int            m;
    for (int k = 0; k < NK; k++) fin(k, cyc);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NK; k++)
        for (int kind = 0; kind < 3; kind++) begin
          e.delete();
          a.delete();
          foreach (exp_q[i])
            if (exp_q[i].k == k && exp_q[i].kind == kind && !(d == 1 && kind == 2)) e.push_back(exp_q[i]);
          foreach (act_q[i])
            if (act_q[i].d == d && act_q[i].k == k && act_q[i].kind == kind) a.push_back(act_q[i]);
          chk_eq($sformatf("%s d%0d k%0d %s count", tag, d, k, kn[kind]), a.size(), e.size());
          m = (a.size() < e.size()) ? a.size() : e.size();
          for (int i = 0; i < m; i++)
            chk_win($sformatf("%s d%0d k%0d %s #%0d", tag, d, k, kn[kind], i), a[i].t, e[i].lo, e[i].hi);
        end
    for (int k = 0; k < NK; k++) want[k] = !pressed[k];
    for (int d = 0; d < 2; d++) chk_eq($sformatf("%s d%0d key_state", tag, d), st[d], want);
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic do_reset(input int n);
    flush("pre-reset");
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("reset d%0d key_state", d), st[d], {NK{1'b1}});
      chk_eq($sformatf("reset d%0d pulses", d), {pr[d], rl[d], rp[d]}, 0);
    end
    repeat (n) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      pressed[k]   = 1'b0;
      seen[k]      = 1'b0;
      seg_start[k] = cyc;
      lvl[k]       = key[k];
    end
    rst_n = 1'b1;
  endtask

  task automatic pair_check(input string tag);
    int t0, t1;
    for (int d = 0; d < 2; d++) begin
      t0 = -1;
      t1 = -1;
      foreach (act_q[i])
        if (act_q[i].d == d && act_q[i].kind == 0) begin
          if (act_q[i].k == 0) t0 = act_q[i].t;
          else                 t1 = act_q[i].t;
        end
      chk_eq($sformatf("%s d%0d same-cycle press", tag, d), t1, t0);
    end
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      lvl[k]       = 1'b1;
      pressed[k]   = 1'b0;
      seen[k]      = 1'b0;
      seg_start[k] = 0;
      next_rep[k]  = 0;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("init d%0d key_state", d), st[d], {NK{1'b1}});
      chk_eq($sformatf("init d%0d pulses", d), {pr[d], rl[d], rp[d]}, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < NK; k++) seg_start[k] = cyc;
    seg(2'b11, 20);
    for (int r = 0; r < 2; r++) begin
      seg(2'b10, 40 + $urandom_range(0, 20));
      flush("t1 hold");
      seg(2'b10, 30 + $urandom_range(0, 25));
      seg(2'b11, 60);
      flush("t1 clean");
    end
    for (int i = 0; i < 10; i++) seg((i % 2 == 0) ? 2'b10 : 2'b11, $urandom_range(4, 12));
    seg(2'b11, 40);
    flush("t2 bounce");
    for (int r = 0; r < 2; r++) begin
      seg(2'b10, 185 + $urandom_range(0, 10));
      seg(2'b11, 60);
      flush("t3 repeat");
    end
    for (int r = 0; r < 2; r++) begin
      seg(2'b10, 100 + $urandom_range(0, 15));
      seg(2'b11, $urandom_range(6, 12));
      seg(2'b10, 115 + $urandom_range(0, 10));
      seg(2'b11, 60);
      flush("t4 glitch");
    end
    seg(2'b10, 140 + $urandom_range(0, 10));
    do_reset(5);
    seg(2'b10, 50);
    flush("t5 after reset");
    seg(2'b11, 60);
    flush("t5 release");
    seg(2'b00, 300);
    seg(2'b11, 60);
    pair_check("t6");
    flush("t6 both");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
